// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice: default widths, reset PC,
// sequential step, and the {pc, instr} entry held in the prefetch queue.
package if_pkg;

  localparam int unsigned        IF_XLEN     = 32;
  localparam int unsigned        IF_PC_STEP  = 4;
  localparam logic [IF_XLEN-1:0] IF_RESET_PC = '0;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned IF_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush. The head entry is read straight from the
// registered storage, so the output never depends on this cycle's push.
module sync_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = IF_ENTRY_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Prefetching fetch stage: credit-limited request issue to a variable-latency
// instruction memory, in-order response queue, branch redirect with squash.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int unsigned      XLEN     = IF_XLEN,
  parameter int unsigned      QDEPTH   = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IF_RESET_PC),
  parameter int unsigned      PC_STEP  = IF_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            isbranchtaken,
  input  logic [XLEN-1:0] branchpc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruct,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned     CW           = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] STEP         = XLEN'(PC_STEP);
  localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(QDEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [XLEN-1:0]   target_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     q_count;
  logic [CW:0]       in_flight;
  logic              req_fire;
  logic              rsp_drop;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [2*XLEN-1:0] q_wdata;
  logic [2*XLEN-1:0] q_rdata;

  assign target_pc = branchpc & ~XLEN'(3);

  // Every issued request owns a queue slot until popped, so the queue cannot overflow.
  assign in_flight      = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = !rst && !isbranchtaken && (in_flight < CREDIT_LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response arriving in the redirect cycle belongs to the old path as well.
  assign rsp_drop = imem_rsp_valid && (isbranchtaken || (drop_cnt != '0));
  assign q_push   = imem_rsp_valid && !rsp_drop;
  assign q_pop    = instr_valid && instr_ready && !isbranchtaken;
  assign q_wdata  = {rsp_pc, imem_rsp_data};

  assign instr_valid          = !q_empty;
  assign {instr_pc, instruct} = q_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (isbranchtaken) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (q_push) begin
          rsp_pc <= rsp_pc + STEP;
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (q_push),
    .pop     (q_pop),
    .flush   (isbranchtaken),
    .wr_data (q_wdata),
    .rd_data (q_rdata),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding == '0)));
  a_q_count_bound: assert property (@(posedge clk) disable iff (rst)
    q_count <= CW'(QDEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_full && q_push && !q_pop));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: streaming, stall/credit, branch squash,
// PC wrap and asynchronous reset, against a variable-latency memory model.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        isbranchtaken;
  logic [31:0] branchpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruct;
  logic [31:0] instr_pc;

  logic        rst_w;
  logic        req_valid_w;
  logic [31:0] req_addr_w;
  logic        instr_valid_w;
  logic [31:0] instruct_w;
  logic [31:0] instr_pc_w;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;
  int acc_cnt;
  int cyc;
  int          due_q[$];
  logic [31:0] addr_q[$];

  if_prefetch_unit #(
    .XLEN(32), .QDEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .isbranchtaken(isbranchtaken), .branchpc(branchpc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruct(instruct), .instr_pc(instr_pc)
  );

  if_prefetch_unit #(
    .XLEN(32), .QDEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
  ) dut_wrap (
    .clk(clk), .rst(rst_w), .isbranchtaken(1'b0), .branchpc(32'h0),
    .imem_req_valid(req_valid_w), .imem_req_ready(1'b1),
    .imem_req_addr(req_addr_w), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .instruct(instruct_w), .instr_pc(instr_pc_w)
  );

  // Memory: answers each accepted request 'lat' cycles later with data = addr + 0x1000_0000.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      due_q.delete();
      addr_q.delete();
      cyc            <= 0;
      acc_cnt        <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        due_q.push_back(cyc + lat);
        addr_q.push_back(imem_req_addr);
        acc_cnt <= acc_cnt + 1;
      end
      if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= addr_q[0] + 32'h1000_0000;
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1; isbranchtaken = 1'b0; branchpc = '0;
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instruct", instruct, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_w_req_valid", req_valid_w, 0);
    chk("rst_w_instr_valid", instr_valid_w, 0);
    chk("rst_w_instr_pc", instr_pc_w, 0);
    chk("rst_w_instruct", instruct_w, 0);

    // Streaming, 1-cycle memory, decode always ready
    next_cycle(); rst = 1'b0;
    mid();
    chk("s_c0_req_valid", imem_req_valid, 1);
    chk("s_c0_addr", imem_req_addr, 32'h0);
    chk("s_c0_instr_valid", instr_valid, 0);
    next_cycle(); mid();
    chk("s_c1_addr", imem_req_addr, 32'h4);
    chk("s_c1_instr_valid", instr_valid, 0);
    next_cycle(); mid();
    chk("s_c2_instr_valid", instr_valid, 1);
    chk("s_c2_pc", instr_pc, 32'h0);
    chk("s_c2_instruct", instruct, 32'h1000_0000);
    chk("s_c2_addr", imem_req_addr, 32'h8);
    next_cycle(); mid();
    chk("s_c3_pc", instr_pc, 32'h4);
    next_cycle(); mid();
    chk("s_c4_pc", instr_pc, 32'h8);

    // Branch coinciding with a response and a decode handshake
    next_cycle(); isbranchtaken = 1'b1; branchpc = 32'h0000_0202;
    mid();
    chk("b_c5_pc", instr_pc, 32'hC);
    chk("b_c5_instruct", instruct, 32'h1000_000C);
    chk("b_c5_req_valid", imem_req_valid, 0);
    chk("b_c5_rsp_valid", imem_rsp_valid, 1);
    next_cycle(); isbranchtaken = 1'b0;
    mid();
    chk("b_c6_instr_valid", instr_valid, 0);
    chk("b_c6_req_valid", imem_req_valid, 1);
    chk("b_c6_addr", imem_req_addr, 32'h200);
    next_cycle(); mid();
    chk("b_c7_instr_valid", instr_valid, 0);
    next_cycle(); mid();
    chk("b_c8_instr_valid", instr_valid, 1);
    chk("b_c8_pc", instr_pc, 32'h200);
    chk("b_c8_instruct", instruct, 32'h1000_0200);
    next_cycle(); mid();
    chk("b_c9_pc", instr_pc, 32'h204);
    next_cycle(); mid();
    chk("b_c10_pc", instr_pc, 32'h208);

    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    chk("ar_instr_valid", instr_valid, 0);
    chk("ar_req_valid", imem_req_valid, 0);
    chk("ar_instr_pc", instr_pc, 0);
    chk("ar_instruct", instruct, 0);
    next_cycle(); rst = 1'b0;
    mid();
    chk("ar_c0_req_valid", imem_req_valid, 1);
    chk("ar_c0_addr", imem_req_addr, 32'h0);
    next_cycle(); next_cycle(); mid();
    chk("ar_c2_pc", instr_pc, 32'h0);
    chk("ar_c2_instruct", instruct, 32'h1000_0000);

    // Decode stall: credits run out after QDEPTH requests
    next_cycle(); rst = 1'b1; instr_ready = 1'b0;
    next_cycle(); rst = 1'b0;
    repeat (10) next_cycle();
    mid();
    chk("st_c10_pc", instr_pc, 32'h0);
    chk("st_c10_instruct", instruct, 32'h1000_0000);
    repeat (9) next_cycle();
    mid();
    chk("st_c19_accepted", acc_cnt, 4);
    chk("st_c19_req_valid", imem_req_valid, 0);
    chk("st_c19_instr_valid", instr_valid, 1);
    chk("st_c19_pc", instr_pc, 32'h0);
    chk("st_c19_instruct", instruct, 32'h1000_0000);
    next_cycle(); instr_ready = 1'b1;
    mid();
    chk("st_c20_pc", instr_pc, 32'h0);
    chk("st_c20_req_valid", imem_req_valid, 0);
    next_cycle(); mid();
    chk("st_c21_pc", instr_pc, 32'h4);
    chk("st_c21_req_valid", imem_req_valid, 1);
    chk("st_c21_addr", imem_req_addr, 32'h10);
    next_cycle(); mid();
    chk("st_c22_pc", instr_pc, 32'h8);
    next_cycle(); mid();
    chk("st_c23_pc", instr_pc, 32'hC);
    next_cycle(); mid();
    chk("st_c24_valid", instr_valid, 1);
    chk("st_c24_pc", instr_pc, 32'h10);
    chk("st_c24_instruct", instruct, 32'h1000_0010);

    // 3-cycle memory, branch with two requests outstanding
    next_cycle(); rst = 1'b1; lat = 3;
    next_cycle(); rst = 1'b0;
    mid();
    chk("l3_c0_addr", imem_req_addr, 32'h0);
    next_cycle(); mid();
    chk("l3_c1_addr", imem_req_addr, 32'h4);
    next_cycle(); isbranchtaken = 1'b1; branchpc = 32'h0000_0103;
    mid();
    chk("l3_c2_req_valid", imem_req_valid, 0);
    next_cycle(); isbranchtaken = 1'b0;
    mid();
    chk("l3_c3_req_valid", imem_req_valid, 1);
    chk("l3_c3_addr", imem_req_addr, 32'h100);
    chk("l3_c3_rsp_valid", imem_rsp_valid, 1);
    chk("l3_c3_instr_valid", instr_valid, 0);
    next_cycle(); mid();
    chk("l3_c4_rsp_valid", imem_rsp_valid, 1);
    chk("l3_c4_instr_valid", instr_valid, 0);
    chk("l3_c4_addr", imem_req_addr, 32'h104);
    next_cycle(); mid();
    chk("l3_c5_instr_valid", instr_valid, 0);
    chk("l3_c5_addr", imem_req_addr, 32'h108);
    next_cycle(); mid();
    chk("l3_c6_instr_valid", instr_valid, 0);
    next_cycle(); mid();
    chk("l3_c7_instr_valid", instr_valid, 1);
    chk("l3_c7_pc", instr_pc, 32'h100);
    chk("l3_c7_instruct", instruct, 32'h1000_0100);
    next_cycle(); mid();
    chk("l3_c8_pc", instr_pc, 32'h104);

    // PC wrap from RESET_PC = FFFF_FFF8, memory never answers
    next_cycle(); rst_w = 1'b0;
    mid();
    chk("w_c0_req_valid", req_valid_w, 1);
    chk("w_c0_addr", req_addr_w, 32'hFFFF_FFF8);
    next_cycle(); mid();
    chk("w_c1_addr", req_addr_w, 32'hFFFF_FFFC);
    next_cycle(); mid();
    chk("w_c2_addr", req_addr_w, 32'h0000_0000);
    next_cycle(); mid();
    chk("w_c3_addr", req_addr_w, 32'h0000_0004);
    next_cycle(); mid();
    chk("w_c4_req_valid", req_valid_w, 0);
    chk("w_c4_instr_valid", instr_valid_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised successor to the single-cycle fetch stage. It generates sequential PCs, issues requests to a variable-latency instruction memory through a valid/ready handshake, and buffers in-order responses in a prefetch queue. It presents instructions to decode with a valid/ready handshake. Taken branches redirect the fetch PC, flush the queue and squash in-flight responses.

Parameters:
XLEN, 32, data/address width (instruction width = XLEN)
QDEPTH, 4, prefetch queue entries (power of 2, >=2); also the maximum number of outstanding requests plus queued entries
RESET_PC, 32'h0, fetch PC after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
isbranchtaken  in  1  redirect strobe, one cycle
branchpc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request byte address
imem_rsp_valid  in  1  response valid, in request order, earliest one cycle after acceptance
imem_rsp_data  in  XLEN  response instruction
instr_valid  out  1  queue head valid
instr_ready  in  1  decode consumes head
instruct  out  XLEN  head instruction
instr_pc  out  XLEN  PC of head instruction

Behaviour:
- Reset (asynchronous, active-high): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0. imem_req_valid=0, instr_valid=0, instruct=0, instr_pc=0.
- Credit rule: imem_req_valid = !isbranchtaken && (outstanding + q_count + pending_drops_in_queue... simplified to outstanding + q_count) < QDEPTH. This guarantees the queue never overflows. imem_req_addr = fetch_pc.
- Request accepted (valid && ready): fetch_pc += PC_STEP, wrapping modulo 2^XLEN; outstanding += 1.
- Response: outstanding -= 1. If drop_cnt > 0, the data is discarded and drop_cnt -= 1. Otherwise {fetch-order PC, data} is pushed into the queue. Response PCs are tracked by a separate rsp_pc register that advances by PC_STEP on each accepted, non-dropped response.
- Output: instruct/instr_pc come registered from the queue head. instr_valid = queue non-empty. Pop on instr_valid && instr_ready.
- Minimum latency: request accepted in cycle N, response in N+1, instr_valid in N+2.
- Branch (isbranchtaken=1) in cycle B:
  - The queue is cleared at the edge.
  - fetch_pc <= {branchpc[XLEN-1:2],2'b00}; rsp_pc <= the same value.
  - drop_cnt <= outstanding minus any response accepted in cycle B. The cycle-B response itself is dropped.
  - No request is issued in cycle B. imem_req_valid may fall without acceptance; the memory must tolerate request withdrawal.
  - The decode handshake in cycle B is ignored (no pop is counted).
  - A request accepted in cycle B+1 uses the target address.
- Branch during drop: drop_cnt is reloaded with the current outstanding count, not accumulated.
- Simultaneous push and pop on a full queue is legal (count unchanged). Push on an empty queue with instr_ready=1: the entry appears at the head next cycle and is not bypassed.
- Stall: instr_ready=0 lets the queue fill. Requests then stop through the credit rule. instruct/instr_pc stay stable while instr_valid && !instr_ready.
- rst mid-operation: all state clears immediately. Late responses after reset are ignored only if they arrive while rst is high. The memory is reset by the same rst.
- Assertions: rsp_valid with outstanding==0 is an error. q_count never exceeds QDEPTH.

Decomposition:
- Shared package if_pkg: XLEN default, PC_STEP, RESET_PC, and a fetch-entry struct {pc, instr}.
- Sub-module: sync_fifo (parametrised width/depth, push/pop/flush, count, full/empty). It is instantiated once with width 2*XLEN. Credit, drop and PC logic live in if_prefetch_unit.

Test Plan:
- Reset release, memory always ready with 1-cycle response, instr_ready=1 -> instr_pc sequence 0,4,8,12 on consecutive cycles starting cycle 2; imem_req_addr 0,4,8,...
- instr_ready=0 for 20 cycles, QDEPTH=4 -> exactly 4 requests accepted; imem_req_valid=0 afterwards; release -> PCs 0,4,8,12 then 16 with no gap beyond 2 cycles.
- 3-cycle memory latency, branch to 0x103 while 2 requests are outstanding -> both responses dropped; next instr_pc=0x100 and imem_req_addr=0x100 in cycle B+1; no stale instruction is ever valid.
- Branch in the same cycle as a response and a decode handshake -> queue empty in cycle B+1; the response is not delivered; drop_cnt counts correctly.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Assert rst asynchronously mid-burst -> instr_valid and imem_req_valid drop to 0 without waiting for a clock edge; fetch restarts at RESET_PC after release.
